// File: rtl/mem_except_unit.sv
// mem_except_unit: E-stage memory exception detect, prioritise and capture until trap_ack
module mem_except_unit #(
    parameter int N     = 64,
    parameter int NREG  = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_E,
    input  logic              flush,
    input  logic [N-1:0]      DM_addr,
    input  logic [1:0]        memOp,
    input  logic [1:0]        memSize,
    input  logic              ebreak_E,
    input  logic [NREG-1:0]   region_en,
    input  logic [NREG*N-1:0] region_base,
    input  logic [NREG*N-1:0] region_limit,
    input  logic [NREG*2-1:0] region_perm,
    input  logic              trap_ack,
    output logic [6:0]        exceptSignal,
    output logic              except_valid,
    output logic [3:0]        except_cause,
    output logic [N-1:0]      except_tval,
    output logic              stall_req,
    output logic [CNT_W-1:0]  except_count
);
    typedef enum logic {IDLE, PENDING} state_t;
    state_t state, state_nx;
    logic active, is_load, is_store, misal, hit, bp, ld_mis, st_mis, ld_acc, st_acc, any;
    logic [1:0] perm;
    logic [N-1:0] mask;
    logic [3:0] cause;
    assign active   = valid_E && !flush;
    assign is_load  = memOp == 2'b01;
    assign is_store = memOp[1];
    assign mask     = (N'(1) << memSize) - N'(1);
    assign misal    = |(DM_addr & mask);
    // scan downward so the lowest-index hit region overrides the rest
    always_comb begin
        hit  = 1'b0;
        perm = 2'b00;
        for (int i = NREG - 1; i >= 0; i--)
            if (region_en[i] && DM_addr >= region_base[i*N +: N] && DM_addr < region_limit[i*N +: N]) begin
                hit  = 1'b1;
                perm = region_perm[i*2 +: 2];
            end
    end
    assign bp     = active && ebreak_E;
    assign ld_mis = active && is_load && misal;
    assign st_mis = active && is_store && misal;
    assign ld_acc = active && is_load && !misal && !(hit && perm[0]);
    assign st_acc = active && is_store && !misal && !(hit && perm[1]);
    assign exceptSignal = {bp, 2'b00, st_acc, st_mis, ld_acc, ld_mis};
    assign any = |exceptSignal;
    assign cause = bp ? 4'd3 : st_mis ? 4'd6 : ld_mis ? 4'd4 : st_acc ? 4'd7 : 4'd5;
    always_comb begin
        state_nx = state;
        if (state == IDLE && any)
            state_nx = PENDING;
        else if (state == PENDING && trap_ack)
            state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            except_cause <= '0;
            except_tval  <= '0;
            except_count <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any) begin
                except_cause <= cause;
                except_tval  <= bp ? '0 : DM_addr;
                except_count <= &except_count ? except_count : except_count + CNT_W'(1);
            end else if (state == PENDING && trap_ack) begin
                except_cause <= '0;
                except_tval  <= '0;
            end
        end
    end
    assign except_valid = state == PENDING;
    assign stall_req    = state == PENDING;
endmodule

// File: tb/tb_mem_except_unit.sv
// tb_mem_except_unit: directed stimulus, queued expected captures checked by a monitor
module tb_mem_except_unit;
    localparam int N = 64, NREG = 4, CNT_W = 4;
    logic clk = 0, reset = 0;
    logic valid_E = 0, flush = 0, ebreak_E = 0, trap_ack = 0;
    logic [N-1:0] DM_addr = '0;
    logic [1:0] memOp = '0, memSize = '0;
    logic [NREG-1:0] region_en = '0;
    logic [NREG*N-1:0] region_base = '0, region_limit = '0;
    logic [NREG*2-1:0] region_perm = '0;
    logic [6:0] exceptSignal;
    logic except_valid, stall_req;
    logic [3:0] except_cause;
    logic [N-1:0] except_tval;
    logic [CNT_W-1:0] except_count;
    int total = 0, passed = 0, exp_cnt = 0;
    logic pv = 0;
    logic [67:0] sb[$];

    mem_except_unit #(.N(N), .NREG(NREG), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .valid_E(valid_E), .flush(flush), .DM_addr(DM_addr),
        .memOp(memOp), .memSize(memSize), .ebreak_E(ebreak_E), .region_en(region_en),
        .region_base(region_base), .region_limit(region_limit), .region_perm(region_perm),
        .trap_ack(trap_ack), .exceptSignal(exceptSignal), .except_valid(except_valid),
        .except_cause(except_cause), .except_tval(except_tval), .stall_req(stall_req),
        .except_count(except_count));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // monitor: each rising except_valid must match the oldest expected capture
    always @(negedge clk) begin
        if (!reset) pv = 0;
        else begin
            if (except_valid && !pv) begin
                if (sb.size() == 0) chk("unexpected_capture", 64'd1, 64'd0);
                else begin
                    logic [67:0] e;
                    e = sb.pop_front();
                    chk("cause", {60'd0, except_cause}, {60'd0, e[67:64]});
                    chk("tval", except_tval, e[63:0]);
                    chk("stall", {63'd0, stall_req}, 64'd1);
                end
            end
            pv = except_valid;
        end
    end

    task automatic set_region(input int i, input logic [N-1:0] b, input logic [N-1:0] l, input logic [1:0] p);
        region_en[i] = 1'b1;
        region_base[i*N +: N] = b;
        region_limit[i*N +: N] = l;
        region_perm[i*2 +: 2] = p;
    endtask

    task automatic apply(input string name, input logic [N-1:0] a, input logic [1:0] op, input logic [1:0] sz,
                         input logic b, input logic fl, input logic [6:0] exp_sig,
                         input logic push, input logic [3:0] c, input logic [N-1:0] tv);
        valid_E = 1; DM_addr = a; memOp = op; memSize = sz; ebreak_E = b; flush = fl;
        #1 chk(name, {57'd0, exceptSignal}, {57'd0, exp_sig});
        if (push) begin sb.push_back({c, tv}); exp_cnt = exp_cnt >= 15 ? 15 : exp_cnt + 1; end
        @(posedge clk); #1;
        valid_E = 0; memOp = 0; ebreak_E = 0; flush = 0;
    endtask

    task automatic ack(input string name);
        trap_ack = 1;
        @(posedge clk); #1;
        trap_ack = 0;
        chk({name, "_valid"}, {63'd0, except_valid}, 64'd0);
        chk({name, "_cause"}, {60'd0, except_cause}, 64'd0);
        chk({name, "_tval"}, except_tval, 64'd0);
        chk({name, "_count"}, {60'd0, except_count}, 64'(exp_cnt));
    endtask

    initial begin
        #2;
        chk("rst_valid", {63'd0, except_valid}, 64'd0);
        chk("rst_stall", {63'd0, stall_req}, 64'd0);
        chk("rst_cause", {60'd0, except_cause}, 64'd0);
        chk("rst_tval", except_tval, 64'd0);
        chk("rst_count", {60'd0, except_count}, 64'd0);
        @(negedge clk); reset = 1;
        @(posedge clk); #1;
        // 1: misaligned double load inside rw region
        set_region(0, 64'h0, 64'h10000, 2'b11);
        apply("t1_sig", 64'h1004, 2'b01, 2'd3, 0, 0, 7'h01, 1, 4'd4, 64'h1004);
        chk("t1_valid", {63'd0, except_valid}, 64'd1);
        ack("t1_ack");
        // 2: store outside only region
        set_region(0, 64'h0, 64'h1000, 2'b11);
        apply("t2_sig", 64'h2000, 2'b10, 2'd2, 0, 0, 7'h08, 1, 4'd7, 64'h2000);
        ack("t2_ack");
        // 3: lowest-index region decides
        set_region(0, 64'h0, 64'h4000, 2'b01);
        set_region(1, 64'h0, 64'h8000, 2'b11);
        apply("t3_store", 64'h100, 2'b10, 2'd3, 0, 0, 7'h08, 1, 4'd7, 64'h100);
        ack("t3_ack");
        apply("t3_load_ok", 64'h100, 2'b01, 2'd3, 0, 0, 7'h00, 0, 4'd0, 64'h0);
        chk("t3_noval", {63'd0, except_valid}, 64'd0);
        apply("t3_amo", 64'h108, 2'b11, 2'd2, 0, 0, 7'h08, 1, 4'd7, 64'h108);
        ack("t3_amo_ack");
        apply("t3_upper", 64'h5000, 2'b10, 2'd2, 0, 0, 7'h00, 0, 4'd0, 64'h0);
        region_en = '0;
        apply("noregion_load", 64'h40, 2'b01, 2'd0, 0, 0, 7'h02, 1, 4'd5, 64'h40);
        ack("noregion_ack");
        apply("memop0", 64'h3, 2'b00, 2'd3, 0, 0, 7'h00, 0, 4'd0, 64'h0);
        // 4: breakpoint beats misaligned store, later faults ignored
        apply("t4_sig", 64'h101, 2'b10, 2'd1, 1, 0, 7'h44, 1, 4'd3, 64'h0);
        apply("t4_second", 64'h7, 2'b01, 2'd2, 0, 0, 7'h01, 0, 4'd0, 64'h0);
        chk("t4_hold_cause", {60'd0, except_cause}, 64'd3);
        chk("t4_hold_count", {60'd0, except_count}, 64'(exp_cnt));
        trap_ack = 1;
        apply("t4_ack_fault", 64'h7, 2'b01, 2'd2, 0, 0, 7'h01, 0, 4'd0, 64'h0);
        trap_ack = 0;
        chk("t4_dropped", {63'd0, except_valid}, 64'd0);
        trap_ack = 1;
        @(posedge clk); #1 trap_ack = 0;
        chk("idle_ack", {60'd0, except_count}, 64'(exp_cnt));
        // 5: flush / invalid squash, then reset mid-PENDING
        apply("t5_flush", 64'h3, 2'b10, 2'd2, 1, 1, 7'h00, 0, 4'd0, 64'h0);
        valid_E = 0; DM_addr = 64'h3; memOp = 2'b10; memSize = 2'd2;
        #1 chk("t5_invalid", {57'd0, exceptSignal}, 64'd0);
        memOp = 0;
        @(posedge clk); #1;
        chk("t5_nocap", {63'd0, except_valid}, 64'd0);
        apply("t5_fault", 64'h6, 2'b10, 2'd2, 0, 0, 7'h04, 1, 4'd6, 64'h6);
        @(negedge clk); #2 reset = 0;
        #1;
        chk("t5_rst_valid", {63'd0, except_valid}, 64'd0);
        chk("t5_rst_stall", {63'd0, stall_req}, 64'd0);
        chk("t5_rst_cause", {60'd0, except_cause}, 64'd0);
        chk("t5_rst_tval", except_tval, 64'd0);
        chk("t5_rst_count", {60'd0, except_count}, 64'd0);
        exp_cnt = 0;
        @(negedge clk); reset = 1;
        @(posedge clk); #1;
        // 6: counter saturation
        for (int k = 0; k < (1 << CNT_W) + 2; k++) begin
            apply("t6_sig", 64'h11, 2'b01, 2'd1, 0, 0, 7'h01, 1, 4'd4, 64'h11);
            ack("t6_ack");
        end
        chk("t6_sat", {60'd0, except_count}, 64'hF);
        repeat (2) @(posedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
